mem_wb_stage: RTL and testbench

Memory stage of the 16-bit five-stage pipeline. It takes the EX/MEM bundle, performs at most one data-memory access per instruction over a variable-latency request/ready handshake, and stalls upstream while an access is outstanding. It owns the MEM/WB pipeline register and produces the 39-bit `W_out` bundle consumed by the writeback stage. A registered halt makes the stage idle permanently until reset.

---
 rtl/mem_wb_stage_pkg.sv | 58 +++++
 rtl/mem_wb_stage_access_fsm.sv | 92 +++++++++
 rtl/mem_wb_stage.sv | 88 ++++++++
 tb/tb_mem_wb_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM/WB definitions: EX/MEM and MEM/WB bundle layouts, FSM state
// encodings and the bubble constant. The writeback stage imports the same
// W_out layout from here.
package mem_wb_stage_pkg;

   localparam int M_W = 45;   // EX/MEM bundle width
   localparam int W_W = 39;   // MEM/WB bundle width

   // EX/MEM bundle, MSB first: alu_result[44:29] store_data[28:13]
   // src_reg[12:9] wr_reg[8:5] halt[4] regwrite[3] memtoreg[2] memread[1] memwrite[0]
   typedef struct packed {
      logic [15:0] alu_result;
      logic [15:0] store_data;
      logic [3:0]  src_reg;
      logic [3:0]  wr_reg;
      logic        halt;
      logic        regwrite;
      logic        memtoreg;
      logic        memread;
      logic        memwrite;
   } m_bundle_t;

   // MEM/WB bundle, MSB first: alu_result[38:23] mem_data_out[22:7]
   // wr_reg[6:3] halt[2] regwrite[1] memtoreg[0]
   typedef struct packed {
      logic [15:0] alu_result;
      logic [15:0] mem_data_out;
      logic [3:0]  wr_reg;
      logic        halt;
      logic        regwrite;
      logic        memtoreg;
   } w_bundle_t;

   typedef enum logic [1:0] {
      STATE_IDLE   = 2'd0,
      STATE_WAIT   = 2'd1,
      STATE_HALTED = 2'd2
   } state_t;

   localparam w_bundle_t W_BUBBLE = '0;

   // Build the MEM/WB bundle for an instruction leaving the stage. Read data
   // only lands for a pure read; read+write counts as a write.
   function automatic w_bundle_t retire(input m_bundle_t m, input logic [15:0] rdata);
      w_bundle_t r;
      r = W_BUBBLE;
      if (m.halt | m.regwrite | m.memread | m.memwrite) begin
         r.alu_result   = m.alu_result;
         r.mem_data_out = (m.memread && !m.memwrite) ? rdata : 16'h0000;
         r.wr_reg       = m.wr_reg;
         r.halt         = m.halt;
         r.regwrite     = m.regwrite;
         r.memtoreg     = m.memtoreg;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_wb_stage_access_fsm.sv
// mem_access_fsm: data-memory access sequencing for the MEM stage.
// Owns the IDLE/WAIT/HALTED state, the request latches used while an access
// is outstanding, and the stall_M / halted outputs.
module mem_access_fsm
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  m_bundle_t         bundle,      // live EX/MEM bundle
   input  logic [15:0]       wdata_in,    // store data after optional forwarding
   input  logic              mem_ready,
   output state_t            state,
   output m_bundle_t         lat_bundle,  // bundle held while in WAIT
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              stall_M,
   output logic              halted
);

   state_t      state_nxt;
   logic [15:0] lat_wdata;
   logic        access;

   assign access = bundle.memread | bundle.memwrite;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= STATE_IDLE;
      else        state <= state_nxt;
   end

   // Next-state: an unanswered issue waits; a retiring halt bundle parks the stage
   always_comb begin
      state_nxt = state;
      case (state)
         STATE_IDLE: begin
            if (access && !mem_ready) state_nxt = STATE_WAIT;
            else if (bundle.halt)     state_nxt = STATE_HALTED;
         end
         STATE_WAIT: begin
            if (mem_ready) state_nxt = lat_bundle.halt ? STATE_HALTED : STATE_IDLE;
         end
         STATE_HALTED: state_nxt = STATE_HALTED;
         default:      state_nxt = STATE_IDLE;
      endcase
   end

   // Capture the request on the issue edge so it stays stable through WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_bundle <= '0;
         lat_wdata  <= 16'h0000;
      end else if (state == STATE_IDLE && access && !mem_ready) begin
         lat_bundle <= bundle;
         lat_wdata  <= wdata_in;
      end
   end

   // Outputs. stall_M stays high through the cycle mem_ready arrives: the
   // EX/MEM register already holds the following instruction and must not
   // advance past it before this stage returns to IDLE.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = bundle.memwrite;
      mem_addr  = ADDR_W'(bundle.alu_result);
      mem_wdata = wdata_in;
      stall_M   = 1'b0;
      halted    = 1'b0;
      case (state)
         STATE_IDLE: mem_req = access;
         STATE_WAIT: begin
            mem_req   = 1'b1;
            mem_we    = lat_bundle.memwrite;
            mem_addr  = ADDR_W'(lat_bundle.alu_result);
            mem_wdata = lat_wdata;
            stall_M   = 1'b1;
         end
         STATE_HALTED: begin
            stall_M = 1'b1;
            halted  = 1'b1;
         end
         default: ;
      endcase
      // Reset abandons any request at once, whatever M_in shows
      mem_req = mem_req & rst_n;
   end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the 16-bit pipeline plus the MEM/WB register.
// Optional macro MEM_WB_FWD_EN enables MEM-to-MEM store-data forwarding from
// the value currently being written back.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [M_W-1:0]    M_in,
   output logic              stall_M,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [15:0]       mem_rdata,
   output logic [W_W-1:0]    W_out,
   output logic              halted
);

   m_bundle_t   m;
   m_bundle_t   lat;
   w_bundle_t   w_q;
   w_bundle_t   w_d;
   state_t      state;
   logic [15:0] wdata_sel;
   logic        unused_bits;

   assign m     = m_bundle_t'(M_in);
   assign W_out = w_q;

   // Store-data source: forwarded writeback value or the EX/MEM store data
   always_comb begin
`ifdef MEM_WB_FWD_EN
      if (state == STATE_IDLE && m.memwrite && w_q.regwrite &&
          w_q.wr_reg == m.src_reg && m.src_reg != 4'd0)
         wdata_sel = w_q.memtoreg ? w_q.mem_data_out : w_q.alu_result;
      else
         wdata_sel = m.store_data;
`else
      wdata_sel = m.store_data;
`endif
   end

   mem_access_fsm #(.ADDR_W(ADDR_W)) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .bundle     (m),
      .wdata_in   (wdata_sel),
      .mem_ready  (mem_ready),
      .state      (state),
      .lat_bundle (lat),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .stall_M    (stall_M),
      .halted     (halted)
   );

   // Next MEM/WB contents: retire on completion, otherwise a bubble
   always_comb begin
      w_d = W_BUBBLE;
      case (state)
         STATE_IDLE:
            if (!(m.memread | m.memwrite) || mem_ready) w_d = retire(m, mem_rdata);
         STATE_WAIT:
            if (mem_ready) w_d = retire(lat, mem_rdata);
         default: w_d = W_BUBBLE;
      endcase
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_q <= W_BUBBLE;
      else        w_q <= w_d;
   end

   // Fields that only matter upstream of the latches or in some builds
   assign unused_bits = ^{m.src_reg, lat.store_data, lat.src_reg};

   // Read and write on the same bundle is malformed; it is handled as a write
   a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      (state == STATE_IDLE) |-> !(m.memread && m.memwrite));

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vectors with literal
// expectations plus an every-cycle compare against a transaction-level model.
module tb_mem_wb_stage;

   typedef struct packed {
      logic [15:0] alu; logic [15:0] sd; logic [3:0] src; logic [3:0] wr;
      logic halt; logic rw; logic mtr; logic rd; logic wrm;
   } min_t;

   typedef struct packed {
      logic [15:0] alu; logic [15:0] data; logic [3:0] wr;
      logic halt; logic rw; logic mtr;
   } wout_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [44:0] M_in = '0;
   logic        stall_M, mem_req, mem_we, halted;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [38:0] W_out;

   int checks = 0;
   int errors = 0;

   mem_wb_stage #(.ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .M_in(M_in), .stall_M(stall_M),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .W_out(W_out), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [44:0] mk(input logic [15:0] alu, input logic [15:0] sd,
                                      input logic [3:0] src, input logic [3:0] wr,
                                      input logic halt, input logic rw, input logic mtr,
                                      input logic rd, input logic wrm);
      min_t t;
      t = '{alu, sd, src, wr, halt, rw, mtr, rd, wrm};
      return t;
   endfunction

   // ---------------- model ----------------
   logic        hlt, pend_v, n_hlt, n_pend_v, nv = 1'b0;
   min_t        pend, n_pend;
   logic [15:0] pend_wd, n_pwd;
   wout_t       wexp, n_w;

   function automatic wout_t wb_of(input min_t c, input logic [15:0] rdata);
      wout_t r;
      r = '0;
      if (c.halt || c.rw || c.rd || c.wrm)
         r = '{c.alu, (c.rd && !c.wrm) ? rdata : 16'h0, c.wr, c.halt, c.rw, c.mtr};
      return r;
   endfunction

   function automatic logic [15:0] store_val(input min_t c, input wout_t w);
      logic [15:0] v;
      v = c.sd;
`ifdef MEM_WB_FWD_EN
      if (c.wrm && w.rw && w.wr == c.src && c.src != 4'd0) v = w.mtr ? w.data : w.alu;
`endif
      return v;
   endfunction

   always @(negedge clk) begin
      min_t cur;
      logic e_req, e_stall, e_we;
      logic [15:0] e_addr, e_wd;
      if (!rst_n) begin
         hlt = 1'b0; pend_v = 1'b0; wexp = '0; nv = 1'b0;
         chk("rst_w_out", W_out, 0);
         chk("rst_req", mem_req, 0);
         chk("rst_stall", stall_M, 0);
         chk("rst_halted", halted, 0);
      end else begin
         cur = min_t'(M_in);
         e_req = 0; e_stall = 0; e_we = 0; e_addr = 0; e_wd = 0;
         n_w = '0; n_pend_v = pend_v; n_pend = pend; n_pwd = pend_wd;
         chk("m_w_out", W_out, wexp);
         chk("m_halted", halted, hlt);
         if (hlt) e_stall = 1;
         else if (pend_v) begin
            e_req = 1; e_stall = 1; e_we = pend.wrm; e_addr = pend.alu; e_wd = pend_wd;
            if (mem_ready) begin n_w = wb_of(pend, mem_rdata); n_pend_v = 0; end
         end else if (cur.rd || cur.wrm) begin
            e_req = 1; e_we = cur.wrm; e_addr = cur.alu; e_wd = store_val(cur, wexp);
            if (mem_ready) n_w = wb_of(cur, mem_rdata);
            else begin n_pend_v = 1; n_pend = cur; n_pwd = e_wd; end
         end else n_w = wb_of(cur, 16'h0);
         chk("m_stall", stall_M, e_stall);
         chk("m_req", mem_req, e_req);
         if (e_req) begin
            chk("m_we", mem_we, e_we);
            chk("m_addr", mem_addr, e_addr);
            chk("m_wdata", mem_wdata, e_wd);
         end
         n_hlt = hlt | n_w.halt;
         nv = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && nv) begin
         hlt = n_hlt; pend_v = n_pend_v; pend = n_pend; pend_wd = n_pwd; wexp = n_w;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   logic [15:0] fwd_exp;
   int          stall_cnt;

   initial begin
      // Reset state
      #3;
      chk("reset_w_out", W_out, 0);
      chk("reset_stall", stall_M, 0);
      chk("reset_req", mem_req, 0);
      chk("reset_halted", halted, 0);
      step(); rst_n = 1'b1;

      // ALU op, no access
      M_in = mk(16'h1234, 16'h0, 4'd0, 4'd3, 0, 1, 0, 0, 0);
      #2 chk("alu_stall", stall_M, 0); chk("alu_req", mem_req, 0);
      step(); M_in = '0;
      #2 chk("alu_w_out", W_out, {16'h1234, 16'h0000, 4'd3, 3'b010});

      // Load with wait cycles; upstream already holds the next instruction
      step(); M_in = mk(16'h0040, 16'h0, 4'd0, 4'd4, 0, 1, 1, 1, 0);
      #2 chk("ld_issue_req", mem_req, 1); chk("ld_issue_stall", stall_M, 0);
      step(); M_in = mk(16'h0007, 16'h0, 4'd0, 4'd6, 0, 1, 0, 0, 0);
      stall_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin mem_ready = 1'b1; mem_rdata = 16'hBEEF; end
         #2 chk("ld_wait_addr", mem_addr, 16'h0040);
         chk("ld_wait_w_out", W_out, 0);
         if (stall_M) stall_cnt++;
         step();
      end
      mem_ready = 1'b0;
      chk("ld_stall_cycles", stall_cnt, 4);
      #2 chk("ld_w_out", W_out, {16'h0040, 16'hBEEF, 4'd4, 3'b011});
      chk("ld_resume_stall", stall_M, 0);
      step(); M_in = '0;
      #2 chk("held_alu_w_out", W_out, {16'h0007, 16'h0000, 4'd6, 3'b010});

      // Zero-wait store then load, back to back
      step(); M_in = mk(16'h0010, 16'h5A5A, 4'd2, 4'd0, 0, 0, 0, 0, 1); mem_ready = 1'b1;
      #2 chk("st_req", mem_req, 1); chk("st_we", mem_we, 1); chk("st_stall", stall_M, 0);
      chk("st_wdata", mem_wdata, 16'h5A5A);
      step(); M_in = mk(16'h0010, 16'h0, 4'd0, 4'd7, 0, 1, 1, 1, 0); mem_rdata = 16'h5A5A;
      #2 chk("ld2_req", mem_req, 1); chk("ld2_we", mem_we, 0); chk("ld2_stall", stall_M, 0);
      chk("st_w_out", W_out, {16'h0010, 16'h0000, 4'd0, 3'b000});
      step(); M_in = '0; mem_ready = 1'b0;
      #2 chk("ld2_w_out", W_out, {16'h0010, 16'h5A5A, 4'd7, 3'b011});

      // Forwarding: load r5 then store from r5
`ifdef MEM_WB_FWD_EN
      fwd_exp = 16'h00AA;
`else
      fwd_exp = 16'h1111;
`endif
      step(); M_in = mk(16'h0020, 16'h0, 4'd0, 4'd5, 0, 1, 1, 1, 0);
      mem_ready = 1'b1; mem_rdata = 16'h00AA;
      step(); M_in = mk(16'h0030, 16'h1111, 4'd5, 4'd0, 0, 0, 0, 0, 1);
      #2 chk("fwd_wdata", mem_wdata, fwd_exp);
      // Forwarded ALU result latched into a waiting store; r0 never forwards
      step(); M_in = mk(16'h0BCD, 16'h0, 4'd0, 4'd9, 0, 1, 0, 0, 0); mem_ready = 1'b0;
      step(); M_in = mk(16'h0032, 16'h2222, 4'd9, 4'd0, 0, 0, 0, 0, 1);
      step(); M_in = mk(16'h0000, 16'h0, 4'd0, 4'd0, 0, 1, 0, 0, 0);
      step(); mem_ready = 1'b1;
      step(); mem_ready = 1'b0; M_in = mk(16'h0034, 16'h3333, 4'd0, 4'd0, 0, 0, 0, 0, 1);
      #2 chk("r0_no_fwd", mem_wdata, 16'h3333);
      mem_ready = 1'b1;
      step(); M_in = '0; mem_ready = 1'b0;

      // Reset during the second wait cycle
      step(); M_in = mk(16'h0050, 16'h0, 4'd0, 4'd1, 0, 1, 1, 1, 0);
      step(); step(); rst_n = 1'b0;
      #1 chk("rstw_req", mem_req, 0); chk("rstw_stall", stall_M, 0);
      chk("rstw_w_out", W_out, 0);
      step(); rst_n = 1'b1; M_in = mk(16'h0ACE, 16'h0, 4'd0, 4'd2, 0, 1, 0, 0, 0);
      #2 chk("post_rst_stall", stall_M, 0); chk("post_rst_req", mem_req, 0);
      step(); M_in = '0;
      #2 chk("post_rst_w_out", W_out, {16'h0ACE, 16'h0000, 4'd2, 3'b010});

      // Halt, then a load that must never be requested
      step(); M_in = mk(16'h0000, 16'h0, 4'd0, 4'd0, 1, 0, 0, 0, 0);
      #2 chk("halt_issue_stall", stall_M, 0);
      step(); M_in = mk(16'h0060, 16'h0, 4'd0, 4'd3, 0, 1, 1, 1, 0); mem_ready = 1'b1;
      #2 chk("halt_halted", halted, 1); chk("halt_stall", stall_M, 1);
      chk("halt_req", mem_req, 0); chk("halt_w_out", W_out, {16'h0, 16'h0, 4'd0, 3'b100});
      step();
      #2 chk("halted_bubble", W_out, 0); chk("halted_req", mem_req, 0);
      step(); step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
